// File: rtl/spw_rx_top_if.sv
// Bundle of the DS line pair and the decoded-character outputs of spw_rx_top.
// master = line driver / link layer side, slave = the receiver.
interface spw_rx_top_if;
    logic       d;
    logic       s;
    logic [7:0] q;
    logic       nchar;
    logic       lchar;
    logic       parityError;
    logic       full_o;
    logic       empty_o;

    modport master (
        output d, s,
        input  q, nchar, lchar, parityError, full_o, empty_o
    );

    modport slave (
        input  d, s,
        output q, nchar, lchar, parityError, full_o, empty_o
    );
endinterface

// File: rtl/spw_rx_top.sv
// SpaceWire DS receiver front end: bit recovery, character framing, odd parity
// check, and an auto-draining character FIFO feeding one-cycle output strobes.
module spw_rx_top #(
    parameter int unsigned DEPTH = 4
) (
    input logic         rxClk,
    input logic         rxReset,
    spw_rx_top_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_PARITY,
        ST_FLAG,
        ST_CTRL,
        ST_DATA,
        ST_HALT
    } state_t;

    logic [1:0] r_d_sync;
    logic [1:0] r_s_sync;
    logic [1:0] r_ds_prev;
    logic [1:0] w_ds;
    logic       w_bit_vld;
    logic       w_bit;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par_bit;
    logic       r_par_acc;
    logic       r_par_err;
    logic       r_push;
    logic [8:0] r_push_data;

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          w_wr;
    logic          w_pop;
    logic          r_full;
    logic          r_empty;
    logic [7:0]    r_q;
    logic          r_nchar;
    logic          r_lchar;

    // A bit is any change of the synchronised pair; simultaneous d/s change counts once.
    assign w_ds      = {r_d_sync[1], r_s_sync[1]};
    assign w_bit_vld = (w_ds != r_ds_prev);
    assign w_bit     = r_d_sync[1];

    always_ff @(posedge rxClk or negedge rxReset) begin
        if (!rxReset) begin
            r_d_sync  <= '0;
            r_s_sync  <= '0;
            r_ds_prev <= '0;
        end else begin
            r_d_sync  <= {r_d_sync[0], bus.d};
            r_s_sync  <= {r_s_sync[0], bus.s};
            r_ds_prev <= w_ds;
        end
    end

    // r_par_acc holds parity of the current character's CTRL/DATA bits, checked
    // against the next character's parity and flag bits.
    always_ff @(posedge rxClk or negedge rxReset) begin
        if (!rxReset) begin
            r_state     <= ST_PARITY;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_bit_vld) begin
                case (r_state)
                    ST_PARITY: begin
                        r_par_bit <= w_bit;
                        r_state   <= ST_FLAG;
                    end
                    ST_FLAG: begin
                        if ((r_par_bit ^ w_bit ^ r_par_acc) == 1'b0) begin
                            r_par_err <= 1'b1;
                            r_state   <= ST_HALT;
                        end else begin
                            r_par_acc <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= w_bit ? ST_CTRL : ST_DATA;
                        end
                    end
                    ST_CTRL: begin
                        r_par_acc <= r_par_acc ^ w_bit;
                        if (r_bit_cnt == 3'd0) begin
                            r_shift[0] <= w_bit;
                            r_bit_cnt  <= 3'd1;
                        end else begin
                            r_push      <= 1'b1;
                            r_push_data <= {1'b0, 6'b0, w_bit, r_shift[0]};
                            r_state     <= ST_PARITY;
                        end
                    end
                    ST_DATA: begin
                        r_par_acc <= r_par_acc ^ w_bit;
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_push      <= 1'b1;
                            r_push_data <= {1'b1, w_bit, r_shift[7:1]};
                            r_state     <= ST_PARITY;
                        end
                    end
                    default: r_state <= ST_HALT;
                endcase
            end
        end
    end

    assign w_pop = (r_count != '0);
    assign w_wr  = r_push && (r_count != FULL_CNT);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + (AW + 1)'(1);
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge rxClk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge rxClk or negedge rxReset) begin
        if (!rxReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_q      <= '0;
            r_nchar  <= 1'b0;
            r_lchar  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_nchar <= 1'b0;
            r_lchar <= 1'b0;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_q      <= r_mem[r_rd_ptr][7:0];
                r_nchar  <= r_mem[r_rd_ptr][8];
                r_lchar  <= ~r_mem[r_rd_ptr][8];
            end
        end
    end

    assign bus.q           = r_q;
    assign bus.nchar       = r_nchar;
    assign bus.lchar       = r_lchar;
    assign bus.parityError = r_par_err;
    assign bus.full_o      = r_full;
    assign bus.empty_o     = r_empty;
endmodule

// File: tb/tb_spw_rx_top.sv
// Directed bench for spw_rx_top: DS-encoded character streams in, decoded
// strobe sequence and flags compared against hand-computed expectations.
module tb_spw_rx_top;
    logic rxClk = 1'b0;
    logic rxReset;

    spw_rx_top_if bus ();

    spw_rx_top #(.DEPTH(4)) dut (
        .rxClk  (rxClk),
        .rxReset(rxReset),
        .bus    (bus.slave)
    );

    always #5 rxClk = ~rxClk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [9:0]  obs_q[$];
    logic [9:0]  exp_q[$];
    logic        full_seen = 1'b0;
    logic        both_seen = 1'b0;
    logic        tb_par    = 1'b0;

    // Observed entry = {lchar, nchar, q}
    always @(negedge rxClk) begin
        if (rxReset === 1'b1) begin
            if (bus.nchar || bus.lchar) obs_q.push_back({bus.lchar, bus.nchar, bus.q});
            if (bus.nchar && bus.lchar) both_seen = 1'b1;
            if (bus.full_o) full_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Exactly one line toggles per bit; 4 clocks per bit.
    task automatic send_bit(input logic b);
        @(posedge rxClk);
        #1;
        if (b == bus.d) bus.s = ~bus.s;
        else            bus.d = b;
        repeat (3) @(posedge rxClk);
    endtask

    task automatic send_char(input logic flag, input logic [7:0] val, input logic bad);
        logic p;
        p = 1'b1 ^ tb_par ^ flag ^ bad;
        send_bit(p);
        send_bit(flag);
        if (flag) begin
            send_bit(val[0]);
            send_bit(val[1]);
            tb_par = val[0] ^ val[1];
        end else begin
            for (int i = 0; i < 8; i++) send_bit(val[i]);
            tb_par = ^val;
        end
    endtask

    task automatic send_ctrl(input logic [1:0] code);
        send_char(1'b1, {6'b0, code}, 1'b0);
        exp_q.push_back({2'b10, 6'b0, code});
    endtask

    task automatic send_data(input logic [7:0] b);
        send_char(1'b0, b, 1'b0);
        exp_q.push_back({2'b01, b});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q"},       32'(bus.q),           32'h0);
        check({tag, "_nchar"},   32'(bus.nchar),       32'h0);
        check({tag, "_lchar"},   32'(bus.lchar),       32'h0);
        check({tag, "_perr"},    32'(bus.parityError), 32'h0);
        check({tag, "_full"},    32'(bus.full_o),      32'h0);
        check({tag, "_empty"},   32'(bus.empty_o),     32'h1);
    endtask

    // Line returned to idle 00 while in reset so no spurious bit follows release.
    task automatic do_reset(input string tag);
        #1;
        rxReset = 1'b0;
        bus.d   = 1'b0;
        bus.s   = 1'b0;
        tb_par  = 1'b0;
        repeat (3) @(posedge rxClk);
        #2;
        check_reset_outputs(tag);
        @(negedge rxClk);
        rxReset = 1'b1;
        obs_q.delete();
        exp_q.delete();
        full_seen = 1'b0;
    endtask

    task automatic compare_obs(input string tag);
        repeat (12) @(posedge rxClk);
        @(negedge rxClk);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check($sformatf("%s_char%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] msg [7];
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
        rxReset = 1'b0;
        bus.d   = 1'b0;
        bus.s   = 1'b0;
        do_reset("rst0");

        // 1: ESC then FCT
        send_ctrl(2'b11);
        send_ctrl(2'b00);
        compare_obs("t1");
        check("t1_perr", 32'(bus.parityError), 32'h0);

        // 2: two NULLs then "Hello\r\n"
        send_ctrl(2'b11); send_ctrl(2'b00);
        send_ctrl(2'b11); send_ctrl(2'b00);
        for (int i = 0; i < 7; i++) send_data(msg[i]);
        compare_obs("t2");
        check("t2_perr", 32'(bus.parityError), 32'h0);

        // 3: bad parity is sticky and halts the decoder
        send_ctrl(2'b11);
        send_char(1'b0, 8'h55, 1'b1);
        send_char(1'b1, 8'h00, 1'b0);
        send_char(1'b0, 8'hA5, 1'b0);
        send_char(1'b1, 8'h01, 1'b0);
        compare_obs("t3");
        check("t3_perr", 32'(bus.parityError), 32'h1);
        repeat (20) @(posedge rxClk);
        check("t3_perr_sticky", 32'(bus.parityError), 32'h1);

        // 4: reset mid data character, then ESC only
        do_reset("rst1");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset("rst2");
        send_ctrl(2'b11);
        compare_obs("t4");
        check("t4_perr", 32'(bus.parityError), 32'h0);

        // 5: FCT, ESC, EOP, EEP
        send_ctrl(2'b00);
        send_ctrl(2'b11);
        send_ctrl(2'b01);
        send_ctrl(2'b10);
        compare_obs("t5");

        // 6: idle, then a burst with auto-drain
        repeat (20) @(posedge rxClk);
        @(negedge rxClk);
        check("t6_idle_empty", 32'(bus.empty_o), 32'h1);
        check("t6_idle_full",  32'(bus.full_o),  32'h0);
        full_seen = 1'b0;
        for (int i = 0; i < 6; i++) send_ctrl(i[1:0]);
        send_data(8'hFF);
        send_data(8'h00);
        compare_obs("t6");
        check("t6_full_seen",  32'(full_seen),    32'h0);
        check("t6_end_empty",  32'(bus.empty_o),  32'h1);
        check("t6_perr",       32'(bus.parityError), 32'h0);
        check("strobe_exclusive", 32'(both_seen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
